cdc_sync_block: RTL and testbench
=================================

Name: cdc_sync_block

Overview:
- Multi-stage flip-flop synchronizer that brings asynchronous level signals into the `clk` domain.
- Used per lane for status flags such as phase-align-done and delay-reset-done.
- Each bit is synchronized independently.
- The block adds no coherency across bits. Callers may pass multi-bit buses only when the bus is gray-coded or holds independent flags.

Parameters:
- WIDTH, 1, number of independent bits synchronized.
- STAGES, 6, number of flip-flops in series per bit. Legal range 2..8. Any other value is an elaboration error (generate-time `$error`).
- INIT_VAL, {WIDTH{1'b0}}, value loaded into every stage at power-up and on reset.

Ports:
- clk  in  1  destination-domain clock. All flops use the rising edge.
- rst  in  1  synchronous reset, active-high. Sampled only on the rising edge of `clk`.
- data_in  in  WIDTH  asynchronous input levels.
- data_out  out  WIDTH  synchronized levels, driven directly from the last stage flop.

Behaviour:
- Per bit b, stage chain s[0]..s[STAGES-1]. On each rising edge of `clk`:
  - s[0] <= data_in[b]
  - s[k] <= s[k-1]
  - data_out[b] = s[STAGES-1]
- There is no combinational path from data_in to data_out.
- Power-up value of every stage flop = INIT_VAL[b], set via an initial value so the block is usable before any reset.
- Reset: if rst=1 at a rising edge, all stages load INIT_VAL on that edge, so data_out = INIT_VAL from the following cycle. Reset has priority over data capture.
- Reset mid-operation: in-flight values are discarded. After rst falls, the first data_in sample reaches data_out after STAGES rising edges.
- Latency: a data_in change that is stable before rising edge N appears on data_out after edge N+STAGES-1, i.e. STAGES cycles.
- An asynchronous change near an edge may resolve to either value; latency is then STAGES or STAGES+1 cycles.
- Pulses on data_in shorter than one `clk` period may be lost. A level held at least 2 `clk` periods is always propagated.
- Once data_in is held constant, data_out is monotonic (no glitching), given metastability resolves within one period.
- Simultaneous multi-bit changes may arrive in different cycles, differing by at most 1 cycle.
- Attribute all stage flops `(* ASYNC_REG = "TRUE" *)`. Place each chain in one slice, and never have synthesis merge or retime them.
- s[0] has no timing path from the source domain. The integrator constrains it with a false path or max-delay.

Optional Feature:
- Macro CDC_SYNC_BLOCK_EDGE_DET_EN.
- When defined, two extra output ports are added:
  - rise_o [WIDTH], one-cycle pulse when data_out goes 0->1.
  - fall_o [WIDTH], one-cycle pulse when data_out goes 1->0.
- Edge outputs are registered. An extra flop prev holds data_out delayed one cycle:
  - rise_o <= data_out & ~prev
  - fall_o <= ~data_out & prev
  - Total latency from data_in is STAGES+1 cycles.
- On rst:
  - prev loads INIT_VAL.
  - rise_o and fall_o clear to 0.
  - Neither reset nor power-up generates a spurious pulse.
- When undefined: the ports and flops are absent, and the core behaviour is unchanged.

Test Plan:
- Reset value: WIDTH=1, STAGES=6, INIT_VAL=0, data_in=1, rst=1 for 3 edges -> data_out=0 throughout; release rst -> data_out=1 exactly 6 edges later.
- Latency: change data_in 0->1 mid-period between edges -> data_out rises after the 6th subsequent edge; 1->0 likewise after 6 edges; no intermediate toggling.
- Mid-operation reset: data_in=1, rst asserted 3 edges after data_in rises, held 1 cycle -> data_out stays 0; data_out=1 6 edges after rst release.
- Multi-bit independence: WIDTH=4, data_in 4'h0->4'hA, stable across edges -> data_out=4'hA after exactly 6 edges; STAGES=2 build -> 4'hA after 2 edges.
- Non-zero INIT_VAL: WIDTH=4, INIT_VAL=4'hF, power-up with no reset -> data_out=4'hF; after 6 edges with data_in=0 -> 4'h0; rst pulse -> 4'hF the next cycle.
- Edge detect (CDC_SYNC_BLOCK_EDGE_DET_EN): data_in 0->1 held 10 cycles then 0 -> rise_o single-cycle pulse 7 edges after the rise, fall_o single pulse 7 edges after the fall; no pulses after reset release with data_in=INIT_VAL.

Source files
------------

// File: rtl/cdc_sync_block.sv
// Multi-stage flop synchronizer for independent asynchronous level bits.
// Optional rise/fall pulse outputs are enabled with `define CDC_SYNC_BLOCK_EDGE_DET_EN.
module cdc_sync_block #(
    parameter int unsigned       WIDTH    = 1,
    parameter int unsigned       STAGES   = 6,
    parameter logic [WIDTH-1:0]  INIT_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
`ifdef CDC_SYNC_BLOCK_EDGE_DET_EN
    ,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
`endif
);

    generate
        if (STAGES < 2 || STAGES > 8) begin : g_bad_stages
            $error("cdc_sync_block: STAGES must be in 2..8");
        end
    endgenerate

    // Entry [0] is the metastability-catching stage; the source-side path into it is unconstrained.
    (* ASYNC_REG = "TRUE", DONT_TOUCH = "TRUE" *)
    logic [STAGES-1:0][WIDTH-1:0] sync_q = {STAGES{INIT_VAL}};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{INIT_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], data_in};
        end
    end

    assign data_out = sync_q[STAGES-1];

`ifdef CDC_SYNC_BLOCK_EDGE_DET_EN
    // prev starts at INIT_VAL so neither power-up nor reset yields a pulse.
    logic [WIDTH-1:0] prev_q = INIT_VAL;
    logic [WIDTH-1:0] rise_q = '0;
    logic [WIDTH-1:0] fall_q = '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= INIT_VAL;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            prev_q <= data_out;
            rise_q <= data_out & ~prev_q;
            fall_q <= ~data_out & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`endif

endmodule

// File: tb/tb_cdc_sync_block.sv
// Scoreboard bench for cdc_sync_block: three instances (6-stage, 6-stage INIT=F, 2-stage).
module tb_cdc_sync_block;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst6 = 1'b0, rstf = 1'b0, rst2 = 1'b0;
    logic [3:0] din6 = 4'h0, dinf = 4'h0, din2 = 4'h0;
    logic [3:0] dout6, doutf, dout2;
`ifdef CDC_SYNC_BLOCK_EDGE_DET_EN
    logic [3:0] rise6, fall6, risef, fallf, rise2, fall2;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] q6[$];
    logic [3:0] q2[$];
    logic [3:0] q_f[$];
    logic [3:0] exp_v;
    logic [3:0] exp_w;

    cdc_sync_block #(.WIDTH(4), .STAGES(6), .INIT_VAL(4'h0)) u_s6 (
        .clk(clk), .rst(rst6), .data_in(din6), .data_out(dout6)
`ifdef CDC_SYNC_BLOCK_EDGE_DET_EN
        , .rise_o(rise6), .fall_o(fall6)
`endif
    );

    cdc_sync_block #(.WIDTH(4), .STAGES(6), .INIT_VAL(4'hF)) u_f (
        .clk(clk), .rst(rstf), .data_in(dinf), .data_out(doutf)
`ifdef CDC_SYNC_BLOCK_EDGE_DET_EN
        , .rise_o(risef), .fall_o(fallf)
`endif
    );

    cdc_sync_block #(.WIDTH(4), .STAGES(2), .INIT_VAL(4'h0)) u_s2 (
        .clk(clk), .rst(rst2), .data_in(din2), .data_out(dout2)
`ifdef CDC_SYNC_BLOCK_EDGE_DET_EN
        , .rise_o(rise2), .fall_o(fall2)
`endif
    );

    task automatic test_power_up();
        #1;
        n_cmp++;
        if (doutf !== 4'hF) begin n_bad++; $display("FAIL power_up_initf: got %h want %h", doutf, 4'hF); end
        n_cmp++;
        if (dout6 !== 4'h0) begin n_bad++; $display("FAIL power_up_init6: got %h want %h", dout6, 4'h0); end
        for (int k = 1; k <= 6; k++) q_f.push_back((k >= 6) ? 4'h0 : 4'hF);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            exp_v = q_f.pop_front();
            n_cmp++;
            if (doutf !== exp_v) begin n_bad++; $display("FAIL power_up_drain k=%0d: got %h want %h", k, doutf, exp_v); end
        end
        @(negedge clk); rstf = 1'b1;
        q_f.push_back(4'hF);
        @(posedge clk); #1;
        exp_v = q_f.pop_front();
        n_cmp++;
        if (doutf !== exp_v) begin n_bad++; $display("FAIL initf_reset: got %h want %h", doutf, exp_v); end
        @(negedge clk); rstf = 1'b0;
        for (int k = 1; k <= 6; k++) q_f.push_back((k >= 6) ? 4'h0 : 4'hF);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            exp_v = q_f.pop_front();
            n_cmp++;
            if (doutf !== exp_v) begin n_bad++; $display("FAIL initf_release k=%0d: got %h want %h", k, doutf, exp_v); end
        end
    endtask

    task automatic test_reset();
        @(negedge clk); din6 = 4'h1; rst6 = 1'b1;
        for (int k = 0; k < 3; k++) q6.push_back(4'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            exp_v = q6.pop_front();
            n_cmp++;
            if (dout6 !== exp_v) begin n_bad++; $display("FAIL reset_hold k=%0d: got %h want %h", k, dout6, exp_v); end
        end
        @(negedge clk); rst6 = 1'b0;
        for (int k = 1; k <= 6; k++) q6.push_back((k >= 6) ? 4'h1 : 4'h0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            exp_v = q6.pop_front();
            n_cmp++;
            if (dout6 !== exp_v) begin n_bad++; $display("FAIL reset_release k=%0d: got %h want %h", k, dout6, exp_v); end
        end
    endtask

    task automatic test_latency();
        logic [3:0] old_v;
        logic [3:0] new_v;
        old_v = 4'h1;
        for (int t = 0; t < 2; t++) begin
            new_v = (t == 0) ? 4'h0 : 4'h1;
            @(negedge clk); din6 = new_v;
            for (int k = 1; k <= 8; k++) q6.push_back((k >= 6) ? new_v : old_v);
            for (int k = 1; k <= 8; k++) begin
                @(posedge clk); #1;
                exp_v = q6.pop_front();
                n_cmp++;
                if (dout6 !== exp_v) begin n_bad++; $display("FAIL latency t=%0d k=%0d: got %h want %h", t, k, dout6, exp_v); end
            end
            old_v = new_v;
        end
    endtask

    task automatic test_multibit();
        @(negedge clk); din6 = 4'h0; din2 = 4'h0;
        repeat (8) @(posedge clk);
        @(negedge clk); din6 = 4'hA; din2 = 4'hA;
        for (int k = 1; k <= 8; k++) begin
            q6.push_back((k >= 6) ? 4'hA : 4'h0);
            q2.push_back((k >= 2) ? 4'hA : 4'h0);
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            exp_v = q6.pop_front();
            exp_w = q2.pop_front();
            n_cmp++;
            if (dout6 !== exp_v) begin n_bad++; $display("FAIL multibit_s6 k=%0d: got %h want %h", k, dout6, exp_v); end
            n_cmp++;
            if (dout2 !== exp_w) begin n_bad++; $display("FAIL multibit_s2 k=%0d: got %h want %h", k, dout2, exp_w); end
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk); din6 = 4'h0;
        repeat (8) @(posedge clk);
        @(negedge clk); din6 = 4'h1;
        for (int k = 0; k < 3; k++) q6.push_back(4'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            exp_v = q6.pop_front();
            n_cmp++;
            if (dout6 !== exp_v) begin n_bad++; $display("FAIL mid_reset_pre k=%0d: got %h want %h", k, dout6, exp_v); end
        end
        @(negedge clk); rst6 = 1'b1;
        q6.push_back(4'h0);
        @(posedge clk); #1;
        exp_v = q6.pop_front();
        n_cmp++;
        if (dout6 !== exp_v) begin n_bad++; $display("FAIL mid_reset_edge: got %h want %h", dout6, exp_v); end
        @(negedge clk); rst6 = 1'b0;
        for (int k = 1; k <= 6; k++) q6.push_back((k >= 6) ? 4'h1 : 4'h0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            exp_v = q6.pop_front();
            n_cmp++;
            if (dout6 !== exp_v) begin n_bad++; $display("FAIL mid_reset_post k=%0d: got %h want %h", k, dout6, exp_v); end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] v;
        // Output after edge k equals the input driven before edge k-5; chain starts full of 1.
        for (int k = 0; k < 5; k++) q6.push_back(4'h1);
        for (int p = 0; p < 22; p++) begin
            v = (p < 16) ? 4'($urandom_range(0, 15)) : 4'h0;
            for (int r = 0; r < 2; r++) begin
                @(negedge clk); din6 = v;
                q6.push_back(v);
                @(posedge clk); #1;
                exp_v = q6.pop_front();
                n_cmp++;
                if (dout6 !== exp_v) begin n_bad++; $display("FAIL back_to_back p=%0d r=%0d: got %h want %h", p, r, dout6, exp_v); end
            end
        end
        q6.delete();
    endtask

`ifdef CDC_SYNC_BLOCK_EDGE_DET_EN
    task automatic test_edge_det();
        logic [3:0] q_rise[$];
        logic [3:0] q_fall[$];
        repeat (4) @(posedge clk);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk); din6 = (k <= 10) ? 4'h1 : 4'h0;
            q_rise.push_back((k == 7) ? 4'h1 : 4'h0);
            q_fall.push_back((k == 17) ? 4'h1 : 4'h0);
            @(posedge clk); #1;
            exp_v = q_rise.pop_front();
            exp_w = q_fall.pop_front();
            n_cmp++;
            if (rise6 !== exp_v) begin n_bad++; $display("FAIL edge_rise k=%0d: got %h want %h", k, rise6, exp_v); end
            n_cmp++;
            if (fall6 !== exp_w) begin n_bad++; $display("FAIL edge_fall k=%0d: got %h want %h", k, fall6, exp_w); end
            n_cmp++;
            if ((risef | fallf | rise2 | fall2) !== 4'h0) begin
                n_bad++; $display("FAIL edge_quiet k=%0d: got %h want %h", k, risef | fallf | rise2 | fall2, 4'h0);
            end
        end
        @(negedge clk); rst6 = 1'b1;
        @(negedge clk); rst6 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ((rise6 | fall6) !== 4'h0) begin n_bad++; $display("FAIL edge_after_reset k=%0d: got %h want %h", k, rise6 | fall6, 4'h0); end
        end
    endtask
`endif

    initial begin
        test_power_up();
        test_reset();
        test_latency();
        test_multibit();
        test_mid_reset();
        test_back_to_back();
`ifdef CDC_SYNC_BLOCK_EDGE_DET_EN
        test_edge_det();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
